// File: rtl/tl_sensor_cond_if.sv
// Detector and light bundle between the sensor front end
// and the left-turn traffic-light controller.
interface tl_sensor_cond_if;
    logic       sa_raw;
    logic       sb_raw;
    logic       sal_raw;
    logic       sbl_raw;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       Ta;
    logic       Tb;
    logic       Tal;
    logic       Tbl;

    modport master (
        output sa_raw, sb_raw, sal_raw, sbl_raw,
        output La, Lb,
        input  Ta, Tb, Tal, Tbl
    );

    modport slave (
        input  sa_raw, sb_raw, sal_raw, sbl_raw,
        input  La, Lb,
        output Ta, Tb, Tal, Tbl
    );
endinterface

// File: rtl/tl_sensor_cond.sv
// Synchronizes and debounces the four vehicle detectors and
// holds left-turn requests until the matching arrow is shown.
module tl_sensor_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input logic              clk,
    input logic              reset,
    tl_sensor_cond_if.slave  io
);
    typedef enum logic [1:0] {
        ST_LO,
        CNT_HI,
        ST_HI,
        CNT_LO
    } deb_st_t;

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Lane order: 0=sa, 1=sb, 2=sal, 3=sbl
    logic [3:0] raw;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] stab;
    logic [3:0] rise;
    logic       req_a;
    logic       req_b;

    assign raw = {io.sbl_raw, io.sal_raw, io.sb_raw, io.sa_raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        deb_st_t          st;
        logic [CNT_W-1:0] cnt;
        logic             lvl;
        logic             done;

        // >= lets DEB_CYCLES=1 leave the count state on the next edge
        assign done    = (cnt >= CNT_END);
        assign rise[g] = (st == CNT_HI) && s2[g] && done;
        assign stab[g] = lvl;

        always_ff @(posedge clk) begin
            if (reset) begin
                st  <= ST_LO;
                cnt <= '0;
                lvl <= 1'b0;
            end else begin
                unique case (st)
                    ST_LO: begin
                        if (s2[g]) begin
                            st  <= CNT_HI;
                            cnt <= CNT_ONE;
                        end
                    end
                    CNT_HI: begin
                        if (!s2[g]) begin
                            st  <= ST_LO;
                            cnt <= '0;
                        end else if (done) begin
                            st  <= ST_HI;
                            cnt <= '0;
                            lvl <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    ST_HI: begin
                        if (!s2[g]) begin
                            st  <= CNT_LO;
                            cnt <= CNT_ONE;
                        end
                    end
                    CNT_LO: begin
                        if (s2[g]) begin
                            st  <= ST_HI;
                            cnt <= '0;
                        end else if (done) begin
                            st  <= ST_LO;
                            cnt <= '0;
                            lvl <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    // An arrow on the same edge as a new press serves that car
    always_ff @(posedge clk) begin
        if (reset) begin
            req_a <= 1'b0;
            req_b <= 1'b0;
        end else begin
            if (io.La == 2'b11)
                req_a <= 1'b0;
            else if (rise[2])
                req_a <= 1'b1;
            if (io.Lb == 2'b11)
                req_b <= 1'b0;
            else if (rise[3])
                req_b <= 1'b1;
        end
    end

    assign io.Ta  = stab[0];
    assign io.Tb  = stab[1];
    assign io.Tal = req_a;
    assign io.Tbl = req_b;
endmodule

// File: tb/tb_tl_sensor_cond.sv
// Randomized and directed checks of tl_sensor_cond against
// a sample-history model of sync, debounce and sticky requests.
module tb_tl_sensor_cond;
    localparam int DEB = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    tl_sensor_cond_if bus ();

    tl_sensor_cond #(
        .DEB_CYCLES(DEB),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit       m_s1   [4];
    bit       m_s2   [4];
    bit       m_stab [4];
    bit [3:0] m_hist [4];
    bit       m_req  [2];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit [3:0] raw;
        bit       rise [4];
        bit       old;
        raw = {bus.sbl_raw, bus.sal_raw, bus.sb_raw, bus.sa_raw};
        if (reset) begin
            for (int g = 0; g < 4; g++) begin
                m_s1[g]   = 0;
                m_s2[g]   = 0;
                m_stab[g] = 0;
                m_hist[g] = '0;
            end
            m_req[0] = 0;
            m_req[1] = 0;
        end else begin
            for (int g = 0; g < 4; g++) begin
                old = m_stab[g];
                m_hist[g] = {m_hist[g][2:0], m_s2[g]};
                // level flips once the last DEB samples all disagree
                if (old ? (m_hist[g] == 4'h0) : (m_hist[g] == 4'hF))
                    m_stab[g] = ~old;
                rise[g] = m_stab[g] & ~old;
                m_s2[g] = m_s1[g];
                m_s1[g] = raw[g];
            end
            if (bus.La == 2'b11) m_req[0] = 0;
            else if (rise[2]) m_req[0] = 1;
            if (bus.Lb == 2'b11) m_req[1] = 0;
            else if (rise[3]) m_req[1] = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("Ta", bus.Ta, m_stab[0]);
        chk("Tb", bus.Tb, m_stab[1]);
        chk("Tal", bus.Tal, m_req[0]);
        chk("Tbl", bus.Tbl, m_req[1]);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_raw(input logic [3:0] v);
        {bus.sbl_raw, bus.sal_raw, bus.sb_raw, bus.sa_raw} = v;
    endtask

    int n;
    logic seen;
    logic tal_before;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_raw(4'hF);
        bus.La = 2'b10;
        bus.Lb = 2'b10;
        @(negedge clk);

        // reset with all detectors active
        steps(2);
        chk("rst_ta", bus.Ta, 0);
        chk("rst_tal", bus.Tal, 0);
        reset = 1'b0;
        n = 0;
        while (n < 12 && bus.Ta !== 1'b1) begin
            step();
            n++;
        end
        chk("lat_ta", n, 6);
        chk("lat_tb", bus.Tb, 1);

        // glitch rejection on sa
        set_raw(4'h0);
        bus.La = 2'b10;
        bus.Lb = 2'b10;
        steps(10);
        set_raw(4'h1);
        steps(3);
        set_raw(4'h0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.Ta) seen = 1'b1;
        end
        chk("glitch", seen, 0);
        set_raw(4'h1);
        steps(6);
        chk("sa_on", bus.Ta, 1);
        set_raw(4'h0);
        steps(2);
        set_raw(4'h1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!bus.Ta) seen = 1'b1;
        end
        chk("dip", seen, 0);

        // sticky left-turn request
        set_raw(4'h5);
        steps(5);
        set_raw(4'h1);
        steps(25);
        chk("sticky", bus.Tal, 1);
        bus.La = 2'b11;
        step();
        chk("served", bus.Tal, 0);
        bus.La = 2'b10;
        steps(10);

        // arrow on the same edge the request rises
        set_raw(4'h5);
        steps(5);
        bus.La = 2'b11;
        step();
        chk("collide", bus.Tal, 0);
        bus.La = 2'b10;
        set_raw(4'h1);
        steps(10);
        set_raw(4'h5);
        steps(10);
        chk("repress", bus.Tal, 1);

        // independence with Lb arrow held
        set_raw(4'h4);
        bus.Lb = 2'b11;
        steps(10);
        tal_before = bus.Tal;
        set_raw(4'hF);
        steps(8);
        chk("ind_ta", bus.Ta, 1);
        chk("ind_tb", bus.Tb, 1);
        chk("ind_tbl", bus.Tbl, 0);
        chk("ind_tal", bus.Tal, tal_before);
        bus.Lb = 2'b10;

        // reset in the middle of an sb count
        set_raw(4'h4);
        steps(10);
        set_raw(4'h6);
        steps(3);
        reset = 1'b1;
        step();
        chk("mid_tal", bus.Tal, 0);
        chk("mid_tb", bus.Tb, 0);
        reset = 1'b0;
        n = 0;
        while (n < 12 && bus.Tb !== 1'b1) begin
            step();
            n++;
        end
        chk("lat_sb", n, 6);

        // random phase
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case (g)
                        0: bus.sa_raw  = ~bus.sa_raw;
                        1: bus.sb_raw  = ~bus.sb_raw;
                        2: bus.sal_raw = ~bus.sal_raw;
                        default: bus.sbl_raw = ~bus.sbl_raw;
                    endcase
                end
            end
            bus.La = ($urandom_range(0, 7) == 0) ? 2'b11
                                                 : 2'($urandom_range(0, 2));
            bus.Lb = ($urandom_range(0, 7) == 0) ? 2'b11
                                                 : 2'($urandom_range(0, 2));
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
